// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction prefetch master: FSM states, fetch granule and FIFO entry.
package instr_fetch_pkg;

    localparam int unsigned IF_ADDR_W   = 18;
    localparam int unsigned IF_DATA_W   = 32;
    localparam int unsigned FETCH_BYTES = IF_DATA_W / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] addr;
        logic [IF_DATA_W-1:0] rdata;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush wins over push and pop.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push;
    assign do_pop  = pop && (count_q != '0);

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/instr_prefetch_master.sv
// Instruction prefetch master: issues sequential word reads, buffers up to DEPTH words, flushes on redirect.
// Optional INSTR_FETCH_BYPASS_EN presents a response directly when the FIFO is empty.
module instr_prefetch_master
    import instr_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = IF_ADDR_W,
    parameter int unsigned           DATA_WIDTH = IF_DATA_W,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 18'h20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_enable_i,
    input  logic                    branch_i,
    input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic [ADDR_WIDTH-1:0]   instr_addr_o,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned           CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(FETCH_BYTES - 1);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  infl_valid_q;
    logic [ADDR_WIDTH-1:0] infl_addr_q;

    fetch_entry_t          resp;
    fetch_entry_t          head;
    fetch_entry_t          fifo_rdata;
    logic                  resp_valid;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        occupancy;
    logic                  room;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_enable_i)  state_d = RUN;
            RUN:     if (!fetch_enable_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffered plus in-flight words must never exceed the FIFO capacity.
    assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(infl_valid_q);
    assign room      = !fifo_full && (occupancy < (CNT_W+1)'(DEPTH));

    always_comb begin
        mem_en_o   = 1'b0;
        mem_addr_o = '0;
        if ((state_q == RUN) && room && !branch_i) begin
            mem_en_o   = 1'b1;
            mem_addr_o = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= BOOT_ADDR;
            infl_valid_q <= 1'b0;
            infl_addr_q  <= '0;
        end else begin
            infl_valid_q <= mem_en_o;
            infl_addr_q  <= mem_addr_o;
            if (branch_i) begin
                ptr_q <= branch_addr_i & ALIGN_MASK;
            end else if (mem_en_o) begin
                ptr_q <= ptr_q + ADDR_WIDTH'(FETCH_BYTES);
            end
        end
    end

    // A response landing in the redirect cycle belongs to the old stream and is dropped.
    assign resp_valid = infl_valid_q && !branch_i;
    assign resp       = '{addr: infl_addr_q, rdata: mem_rdata_i};

`ifdef INSTR_FETCH_BYPASS_EN
    logic bypass;
    assign bypass        = fifo_empty && resp_valid;
    assign instr_valid_o = (!fifo_empty || resp_valid) && !branch_i;
    assign head          = bypass ? resp : fifo_rdata;
    assign fifo_push     = resp_valid && !(bypass && instr_ready_i);
`else
    assign instr_valid_o = !fifo_empty && !branch_i;
    assign head          = fifo_rdata;
    assign fifo_push     = resp_valid;
`endif

    assign fifo_pop = instr_valid_o && instr_ready_i && !fifo_empty;

    instr_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (branch_i),
        .wdata (resp),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_rdata_o = head.rdata;
    assign instr_addr_o  = head.addr;
    assign mem_we_o      = 1'b0;
    assign mem_be_o      = '1;
    assign mem_wdata_o   = '0;

endmodule
